// File: rtl/id_pkg.sv
// Shared decode constants, control bundle and condition evaluation for the ID stage.
package id_pkg;

  // Execute-unit commands
  localparam logic [3:0] ExeNop = 4'b0000;
  localparam logic [3:0] ExeMov = 4'b0001;
  localparam logic [3:0] ExeAdd = 4'b0010;
  localparam logic [3:0] ExeAdc = 4'b0011;
  localparam logic [3:0] ExeSub = 4'b0100;
  localparam logic [3:0] ExeSbc = 4'b0101;
  localparam logic [3:0] ExeAnd = 4'b0110;
  localparam logic [3:0] ExeOrr = 4'b0111;
  localparam logic [3:0] ExeEor = 4'b1000;
  localparam logic [3:0] ExeMvn = 4'b1001;

  // Data-processing opcodes
  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpMvn = 4'b1111;

  // Instruction classes
  localparam logic [1:0] ModeAlu = 2'b00;
  localparam logic [1:0] ModeMem = 2'b01;
  localparam logic [1:0] ModeBr  = 2'b10;
  localparam logic [1:0] ModeNop = 2'b11;

  // Condition codes
  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondMi = 4'b0100;
  localparam logic [3:0] CondPl = 4'b0101;
  localparam logic [3:0] CondVs = 4'b0110;
  localparam logic [3:0] CondVc = 4'b0111;
  localparam logic [3:0] CondHi = 4'b1000;
  localparam logic [3:0] CondLs = 4'b1001;
  localparam logic [3:0] CondGe = 4'b1010;
  localparam logic [3:0] CondLt = 4'b1011;
  localparam logic [3:0] CondGt = 4'b1100;
  localparam logic [3:0] CondLe = 4'b1101;
  localparam logic [3:0] CondAl = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  localparam ctrl_t CtrlNop = '0;

  // sr is {N, Z, C, V}; the reserved code never executes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
    logic n, z, c, v;
    n = sr[3];
    z = sr[2];
    c = sr[1];
    v = sr[0];
    case (cond)
      CondEq:  return z;
      CondNe:  return ~z;
      CondCs:  return c;
      CondCc:  return ~c;
      CondMi:  return n;
      CondPl:  return ~n;
      CondVs:  return v;
      CondVc:  return ~v;
      CondHi:  return c & ~z;
      CondLs:  return ~c | z;
      CondGe:  return n == v;
      CondLt:  return n != v;
      CondGt:  return ~z & (n == v);
      CondLe:  return z | (n != v);
      CondAl:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file_3r1w.sv
// Register file: three combinational read ports with write-through bypass, one write port.
module reg_file_3r1w #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [3:0]        raddr1_i,
  input  logic [3:0]        raddr2_i,
  input  logic [3:0]        raddr3_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] rdata3_o,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  // Register fields are 4 bits wide; only the low bits index a smaller file.
  localparam int unsigned AddrW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [AddrW-1:0]  wa, ra1, ra2, ra3;

  assign wa  = waddr_i[AddrW-1:0];
  assign ra1 = raddr1_i[AddrW-1:0];
  assign ra2 = raddr2_i[AddrW-1:0];
  assign ra3 = raddr3_i[AddrW-1:0];

  // Reset clears every register and wins over a coincident write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(REG_CNT); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[wa] <= wdata_i;
    end
  end

  // Reads see a same-cycle write to the same register.
  always_comb begin
    rdata1_o = (we_i && (wa == ra1)) ? wdata_i : regs_q[ra1];
    rdata2_o = (we_i && (wa == ra2)) ? wdata_i : regs_q[ra2];
    rdata3_o = (we_i && (wa == ra3)) ? wdata_i : regs_q[ra3];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: decode, condition check, register read and the ID/EX register.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_CNT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              wb_wb_en,
  input  logic [3:0]        wb_dest,
  input  logic              hazard,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        sr,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic [3:0]        src3,
  output logic              two_src,
  output logic              three_src,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_r_en,
  output logic              ex_mem_w_en,
  output logic              ex_b,
  output logic              ex_s,
  output logic [3:0]        ex_exe_cmd,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [DATA_W-1:0] ex_val_rs,
  output logic              ex_imm,
  output logic [11:0]       ex_shift_operand,
  output logic [23:0]       ex_signed_imm_24,
  output logic [3:0]        ex_dest
);

  logic [1:0]        mode;
  logic [3:0]        opcode, cond;
  logic              s_bit, imm_bit;
  ctrl_t             dec_ctrl;
  logic              live;
  logic [DATA_W-1:0] rd1, rd2, rd3;

  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] rn_q, rm_q, rs_q;
  logic              imm_q;
  logic [11:0]       shift_q;
  logic [23:0]       simm_q;
  logic [3:0]        dest_q;

  assign mode    = instruction[27:26];
  assign opcode  = instruction[24:21];
  assign s_bit   = instruction[20];
  assign cond    = instruction[31:28];
  assign imm_bit = instruction[25];

  // Raw control decode; unknown opcodes and mode 11 fall back to all-zero controls.
  always_comb begin
    dec_ctrl = CtrlNop;
    unique case (mode)
      ModeAlu: begin
        dec_ctrl.s     = s_bit;
        dec_ctrl.wb_en = 1'b1;
        case (opcode)
          OpMov:   dec_ctrl.exe_cmd = ExeMov;
          OpMvn:   dec_ctrl.exe_cmd = ExeMvn;
          OpAdd:   dec_ctrl.exe_cmd = ExeAdd;
          OpAdc:   dec_ctrl.exe_cmd = ExeAdc;
          OpSub:   dec_ctrl.exe_cmd = ExeSub;
          OpSbc:   dec_ctrl.exe_cmd = ExeSbc;
          OpAnd:   dec_ctrl.exe_cmd = ExeAnd;
          OpOrr:   dec_ctrl.exe_cmd = ExeOrr;
          OpEor:   dec_ctrl.exe_cmd = ExeEor;
          OpCmp: begin
            dec_ctrl.exe_cmd = ExeSub;
            dec_ctrl.wb_en   = 1'b0;
          end
          OpTst: begin
            dec_ctrl.exe_cmd = ExeAnd;
            dec_ctrl.wb_en   = 1'b0;
          end
          default: dec_ctrl = CtrlNop;
        endcase
      end
      ModeMem: begin
        dec_ctrl.exe_cmd  = ExeAdd;
        dec_ctrl.mem_r_en = s_bit;
        dec_ctrl.wb_en    = s_bit;
        dec_ctrl.mem_w_en = ~s_bit;
      end
      ModeBr: begin
        dec_ctrl.b       = 1'b1;
        dec_ctrl.exe_cmd = ExeNop;
      end
      ModeNop: dec_ctrl = CtrlNop;
    endcase
  end

  // Hazard-unit view of operand usage; stores read Rd as their second source.
  always_comb begin
    src1      = instruction[19:16];
    src2      = dec_ctrl.mem_w_en ? instruction[15:12] : instruction[3:0];
    src3      = instruction[11:8];
    two_src   = ~imm_bit | dec_ctrl.mem_w_en;
    three_src = (mode == ModeAlu) & ~imm_bit & instruction[4];
  end

  assign live = instr_valid & ~hazard & cond_pass(cond, sr);

  reg_file_3r1w #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_reg_file (
    .clk_i    (clk),
    .reset_i  (reset),
    .raddr1_i (src1),
    .raddr2_i (src2),
    .raddr3_i (src3),
    .rdata1_o (rd1),
    .rdata2_o (rd2),
    .rdata3_o (rd3),
    .we_i     (wb_wb_en),
    .waddr_i  (wb_dest),
    .wdata_i  (wb_value)
  );

  // ID/EX register: reset > flush > stall > load; bubbles carry data but no controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= CtrlNop;
      rn_q    <= '0;
      rm_q    <= '0;
      rs_q    <= '0;
      imm_q   <= 1'b0;
      shift_q <= '0;
      simm_q  <= '0;
      dest_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= CtrlNop;
    end else if (!stall) begin
      valid_q <= live;
      ctrl_q  <= live ? dec_ctrl : CtrlNop;
      rn_q    <= rd1;
      rm_q    <= rd2;
      rs_q    <= rd3;
      imm_q   <= imm_bit;
      shift_q <= instruction[11:0];
      simm_q  <= instruction[23:0];
      dest_q  <= instruction[15:12];
    end
  end

  assign ex_valid         = valid_q;
  assign ex_wb_en         = ctrl_q.wb_en;
  assign ex_mem_r_en      = ctrl_q.mem_r_en;
  assign ex_mem_w_en      = ctrl_q.mem_w_en;
  assign ex_b             = ctrl_q.b;
  assign ex_s             = ctrl_q.s;
  assign ex_exe_cmd       = ctrl_q.exe_cmd;
  assign ex_val_rn        = rn_q;
  assign ex_val_rm        = rm_q;
  assign ex_val_rs        = rs_q;
  assign ex_imm           = imm_q;
  assign ex_shift_operand = shift_q;
  assign ex_signed_imm_24 = simm_q;
  assign ex_dest          = dest_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: the driver queues expected values per cycle,
// a negedge monitor pops and compares them.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, instr_valid, wb_wb_en, hazard, stall, flush;
  logic [31:0] instruction, wb_value;
  logic [3:0]  wb_dest, sr;
  logic [3:0]  src1, src2, src3;
  logic        two_src, three_src;
  logic        ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_imm;
  logic [3:0]  ex_exe_cmd, ex_dest;
  logic [31:0] ex_val_rn, ex_val_rm, ex_val_rs;
  logic [11:0] ex_shift_operand;
  logic [23:0] ex_signed_imm_24;

  id_stage_pipe #(.DATA_W(32), .REG_CNT(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .instruction      (instruction),
    .instr_valid      (instr_valid),
    .wb_value         (wb_value),
    .wb_wb_en         (wb_wb_en),
    .wb_dest          (wb_dest),
    .hazard           (hazard),
    .stall            (stall),
    .flush            (flush),
    .sr               (sr),
    .src1             (src1),
    .src2             (src2),
    .src3             (src3),
    .two_src          (two_src),
    .three_src        (three_src),
    .ex_valid         (ex_valid),
    .ex_wb_en         (ex_wb_en),
    .ex_mem_r_en      (ex_mem_r_en),
    .ex_mem_w_en      (ex_mem_w_en),
    .ex_b             (ex_b),
    .ex_s             (ex_s),
    .ex_exe_cmd       (ex_exe_cmd),
    .ex_val_rn        (ex_val_rn),
    .ex_val_rm        (ex_val_rm),
    .ex_val_rs        (ex_val_rs),
    .ex_imm           (ex_imm),
    .ex_shift_operand (ex_shift_operand),
    .ex_signed_imm_24 (ex_signed_imm_24),
    .ex_dest          (ex_dest)
  );

  always #5 clk = ~clk;

  typedef enum int {
    FValid, FWbEn, FMemR, FMemW, FB, FS, FCmd, FRn, FRm, FRs, FImm, FShift, FSimm, FDest,
    FSrc1, FSrc2, FSrc3, FTwo, FThree
  } field_e;

  typedef struct {
    int          cyc;
    field_e      f;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input field_e f);
    case (f)
      FValid:  return 32'(ex_valid);
      FWbEn:   return 32'(ex_wb_en);
      FMemR:   return 32'(ex_mem_r_en);
      FMemW:   return 32'(ex_mem_w_en);
      FB:      return 32'(ex_b);
      FS:      return 32'(ex_s);
      FCmd:    return 32'(ex_exe_cmd);
      FRn:     return ex_val_rn;
      FRm:     return ex_val_rm;
      FRs:     return ex_val_rs;
      FImm:    return 32'(ex_imm);
      FShift:  return 32'(ex_shift_operand);
      FSimm:   return 32'(ex_signed_imm_24);
      FDest:   return 32'(ex_dest);
      FSrc1:   return 32'(src1);
      FSrc2:   return 32'(src2);
      FSrc3:   return 32'(src3);
      FTwo:    return 32'(two_src);
      default: return 32'(three_src);
    endcase
  endfunction

  // Monitor: compare every entry due this cycle; leftovers after the drain are failures.
  always @(negedge clk) begin
    exp_t        cur;
    logic [31:0] act;
    while (sb.size() > 0 && (sb[0].cyc <= cyc || done)) begin
      cur = sb.pop_front();
      checks++;
      if (cur.cyc != cyc) begin
        errors++;
        $display("FAIL %s: due at cycle %0d, compared at %0d, required %h",
                 cur.f.name(), cur.cyc, cyc, cur.v);
      end else begin
        act = actual(cur.f);
        if (act !== cur.v) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %h, required %h", cur.f.name(), cyc, act, cur.v);
        end
      end
    end
  end

  task automatic expect_f(input field_e f, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + 1;
    e.f   = f;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic expect_ctrl(input logic vld, input logic wb, input logic mr, input logic mw,
                             input logic b, input logic s, input logic [3:0] cmd);
    expect_f(FValid, 32'(vld));
    expect_f(FWbEn, 32'(wb));
    expect_f(FMemR, 32'(mr));
    expect_f(FMemW, 32'(mw));
    expect_f(FB, 32'(b));
    expect_f(FS, 32'(s));
    expect_f(FCmd, 32'(cmd));
  endtask

  // Present one cycle of inputs; expectations pushed after this apply after the next edge.
  task automatic drive(input logic [31:0] ins, input logic iv, input logic [3:0] s_r,
                       input logic hz, input logic st, input logic fl, input logic rs,
                       input logic we, input logic [3:0] wd, input logic [31:0] wv);
    instruction = ins;
    instr_valid = iv;
    sr          = s_r;
    hazard      = hz;
    stall       = st;
    flush       = fl;
    reset       = rs;
    wb_wb_en    = we;
    wb_dest     = wd;
    wb_value    = wv;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  localparam logic [31:0] Add13 = 32'hE083_1002;

  initial begin
    drive(32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
    tick();

    // Reset with a simultaneous write to R5 that must be dropped
    drive(Add13, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h99);
    expect_ctrl(0, 0, 0, 0, 0, 0, 4'h0);
    expect_f(FRn, 32'h0); expect_f(FRm, 32'h0); expect_f(FRs, 32'h0);
    expect_f(FDest, 32'h0); expect_f(FImm, 32'h0); expect_f(FShift, 32'h0);
    expect_f(FSimm, 32'h0);
    tick();

    // Bubble while writing R3 = 0x55, then R2 = 0x10
    drive(32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h55);
    expect_ctrl(0, 0, 0, 0, 0, 0, 4'h0);
    tick();
    drive(32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h10);
    tick();

    // ADD R1,R3,R2
    drive(Add13, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(1, 1, 0, 0, 0, 0, 4'h2);
    expect_f(FRn, 32'h55); expect_f(FRm, 32'h10); expect_f(FDest, 32'h1);
    expect_f(FImm, 32'h0); expect_f(FShift, 32'h002); expect_f(FSimm, 32'h83_1002);
    expect_f(FSrc1, 32'h3); expect_f(FSrc2, 32'h2); expect_f(FTwo, 32'h1);
    expect_f(FThree, 32'h0);
    tick();

    // R5 must still be zero
    drive(32'hE085_1002, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_f(FRn, 32'h0); expect_f(FSrc1, 32'h5);
    tick();

    // Bypass: write R3 = 0xAA in the same cycle it is read
    drive(Add13, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'hAA);
    expect_f(FRn, 32'hAA); expect_f(FRm, 32'h10);
    tick();

    // ADDNE with Z set is squashed, data still loaded; then with Z clear it executes
    drive(32'h1083_1002, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(0, 0, 0, 0, 0, 0, 4'h0);
    expect_f(FRn, 32'hAA);
    tick();
    drive(32'h1083_1002, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(1, 1, 0, 0, 0, 0, 4'h2);
    tick();

    // Load ADD, then stall three cycles with a different instruction and a write to R4
    drive(Add13, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(1, 1, 0, 0, 0, 0, 4'h2);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'hE1E0_1002 + 32'(i), 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, (i == 0), 4'd4,
            32'h44);
      expect_ctrl(1, 1, 0, 0, 0, 0, 4'h2);
      expect_f(FRn, 32'hAA); expect_f(FRm, 32'h10); expect_f(FDest, 32'h1);
      expect_f(FShift, 32'h002);
      tick();
    end
    // Flush beats stall
    drive(Add13, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(0, 0, 0, 0, 0, 0, 4'h0);
    tick();

    // R4 was written during the stall
    drive(32'hE084_1002, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_f(FRn, 32'h44);
    tick();

    // STR R1,[R2]
    drive(32'hE582_1000, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(1, 0, 0, 1, 0, 0, 4'h2);
    expect_f(FSrc1, 32'h2); expect_f(FSrc2, 32'h1); expect_f(FTwo, 32'h1);
    expect_f(FRn, 32'h10); expect_f(FRm, 32'h0);
    tick();

    // LDR R1,[R2]
    drive(32'hE592_1000, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(1, 1, 1, 0, 0, 0, 4'h2);
    expect_f(FSrc2, 32'h0);
    tick();

    // MOV R1,R2,LSL R3
    drive(32'hE1A0_1312, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(1, 1, 0, 0, 0, 0, 4'h1);
    expect_f(FThree, 32'h1); expect_f(FSrc3, 32'h3); expect_f(FTwo, 32'h1);
    expect_f(FRs, 32'hAA); expect_f(FRm, 32'h10); expect_f(FShift, 32'h312);
    tick();

    // Branch
    drive(32'hEA00_0010, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(1, 0, 0, 0, 1, 0, 4'h0);
    expect_f(FImm, 32'h1); expect_f(FSimm, 32'h00_0010); expect_f(FTwo, 32'h0);
    tick();

    // CMP R3,R2 with S
    drive(32'hE153_0002, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(1, 0, 0, 0, 0, 1, 4'h4);
    expect_f(FRn, 32'hAA);
    tick();

    // ADDS R1,R3,#5
    drive(32'hE293_1005, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(1, 1, 0, 0, 0, 1, 4'h2);
    expect_f(FImm, 32'h1); expect_f(FShift, 32'h005); expect_f(FTwo, 32'h0);
    tick();

    // Hazard bubble still loads data
    drive(Add13, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(0, 0, 0, 0, 0, 0, 4'h0);
    expect_f(FRn, 32'hAA);
    tick();

    // Reserved condition never executes
    drive(32'hF083_1002, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_f(FValid, 32'h0); expect_f(FWbEn, 32'h0);
    tick();

    // Unlisted opcode with S set, then mode 11: no controls
    drive(32'hE073_1002, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_f(FWbEn, 32'h0); expect_f(FS, 32'h0); expect_f(FCmd, 32'h0);
    tick();
    drive(32'hEC83_1002, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_f(FWbEn, 32'h0); expect_f(FMemR, 32'h0); expect_f(FMemW, 32'h0);
    expect_f(FB, 32'h0); expect_f(FCmd, 32'h0);
    tick();

    // Reset during stall with a live ADD held
    drive(Add13, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_f(FWbEn, 32'h1);
    tick();
    drive(Add13, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0);
    expect_ctrl(0, 0, 0, 0, 0, 0, 4'h0);
    expect_f(FRn, 32'h0); expect_f(FRm, 32'h0); expect_f(FDest, 32'h0);
    expect_f(FShift, 32'h0); expect_f(FSimm, 32'h0);
    tick();
    drive(Add13, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    expect_ctrl(1, 1, 0, 0, 0, 0, 4'h2);
    expect_f(FRn, 32'h0); expect_f(FRm, 32'h0); expect_f(FDest, 32'h1);
    tick();

    drive(32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    repeat (4) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
